// File: rtl/host_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : host_bus_pkg
// Description : Shared types, default widths and timing for host_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
package host_bus_pkg;

    localparam int HB_ADDR_W     = 21;
    localparam int HB_DATA_W     = 16;
    localparam int HB_SETUP_CYC  = 2;
    localparam int HB_STROBE_CYC = 4;
    localparam int HB_HOLD_CYC   = 1;
    localparam int HB_TURN_CYC   = 2;
    localparam int HB_CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } hb_state_e;

    // Phase counters run N-1 .. 0, so a phase of N cycles loads N-1.
    function automatic logic [HB_CNT_W-1:0] hb_phase_load(input int cycles);
        return (cycles > 0) ? HB_CNT_W'(cycles - 1) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_bus_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module      : host_bus_phase_cnt
// Description : Loadable down-counter with zero flag, shared by all bus phases.
// Revision    : 1.0 - initial release
// ============================================================================
module host_bus_phase_cnt
    import host_bus_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [HB_CNT_W-1:0] load_val_i,
    input  logic                en_i,
    output logic                zero_o
);

    logic [HB_CNT_W-1:0] cnt_q;

    // Saturates at zero so an idle enable never wraps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - HB_CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/host_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : host_bus_master
// Description : M1-style host bus initiator with programmable phase timing.
// Revision    : 1.0 - initial release
// ============================================================================
module host_bus_master
    import host_bus_pkg::*;
#(
    parameter int ADDR_W     = HB_ADDR_W,
    parameter int DATA_W     = HB_DATA_W,
    parameter int SETUP_CYC  = HB_SETUP_CYC,
    parameter int STROBE_CYC = HB_STROBE_CYC,
    parameter int HOLD_CYC   = HB_HOLD_CYC,
    parameter int TURN_CYC   = HB_TURN_CYC
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              HOST_nCS,
    output logic              HOST_nWE,
    output logic              HOST_nOE,
    output logic [ADDR_W-1:0] HOST_ADD,
    output logic [DATA_W-1:0] HOST_DO,
    output logic              HOST_DOE,
    input  logic [DATA_W-1:0] HOST_DI
);

    localparam logic [HB_CNT_W-1:0] c_setup_ld  = hb_phase_load(SETUP_CYC);
    localparam logic [HB_CNT_W-1:0] c_strobe_ld = hb_phase_load(STROBE_CYC);
    localparam logic [HB_CNT_W-1:0] c_hold_ld   = hb_phase_load(HOLD_CYC);
    localparam logic [HB_CNT_W-1:0] c_turn_ld   = hb_phase_load(TURN_CYC);
    localparam logic                c_has_hold  = (HOLD_CYC != 0);
    localparam logic                c_has_turn  = (TURN_CYC != 0);

    hb_state_e           state_q;
    logic                write_q;
    logic                ncs_q;
    logic                nwe_q;
    logic                noe_q;
    logic                doe_q;
    logic                rsp_valid_q;
    logic [ADDR_W-1:0]   add_q;
    logic [DATA_W-1:0]   do_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic                phase_load;
    logic [HB_CNT_W-1:0] phase_val;
    logic                phase_en;
    logic                phase_zero;

    assign req_ready = (state_q == ST_IDLE) && !RESET;
    assign busy      = (state_q != ST_IDLE);
    assign phase_en  = (state_q != ST_IDLE);

    // Reload the counter on every phase entry; skipped phases are never loaded.
    always_comb begin
        phase_load = 1'b0;
        phase_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    phase_load = 1'b1;
                    phase_val  = c_setup_ld;
                end
            end
            ST_SETUP: begin
                if (phase_zero) begin
                    phase_load = 1'b1;
                    phase_val  = c_strobe_ld;
                end
            end
            ST_STROBE: begin
                if (phase_zero && c_has_hold) begin
                    phase_load = 1'b1;
                    phase_val  = c_hold_ld;
                end else if (phase_zero && c_has_turn) begin
                    phase_load = 1'b1;
                    phase_val  = c_turn_ld;
                end
            end
            ST_HOLD: begin
                if (phase_zero && c_has_turn) begin
                    phase_load = 1'b1;
                    phase_val  = c_turn_ld;
                end
            end
            default: ;
        endcase
    end

    host_bus_phase_cnt u_phase_cnt (
        .clk        (clk),
        .rst        (RESET),
        .load_i     (phase_load),
        .load_val_i (phase_val),
        .en_i       (phase_en),
        .zero_o     (phase_zero)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            ncs_q       <= 1'b1;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            doe_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            add_q       <= '0;
            do_q        <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state_q <= ST_SETUP;
                        write_q <= req_write;
                        ncs_q   <= 1'b0;
                        add_q   <= req_addr;
                        if (req_write) begin
                            do_q  <= req_wdata;
                            doe_q <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (phase_zero) begin
                        state_q <= ST_STROBE;
                        if (write_q) begin
                            nwe_q <= 1'b0;
                        end else begin
                            noe_q <= 1'b0;
                        end
                    end
                end
                ST_STROBE: begin
                    if (phase_zero) begin
                        nwe_q       <= 1'b1;
                        noe_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata_q <= HOST_DI;
                        end
                        if (c_has_hold) begin
                            state_q <= ST_HOLD;
                        end else begin
                            ncs_q   <= 1'b1;
                            doe_q   <= 1'b0;
                            state_q <= c_has_turn ? ST_TURN : ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_zero) begin
                        ncs_q   <= 1'b1;
                        doe_q   <= 1'b0;
                        state_q <= c_has_turn ? ST_TURN : ST_IDLE;
                    end
                end
                ST_TURN: begin
                    if (phase_zero) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign HOST_nCS  = ncs_q;
    assign HOST_nWE  = nwe_q;
    assign HOST_nOE  = noe_q;
    assign HOST_DOE  = doe_q;
    assign HOST_ADD  = add_q;
    assign HOST_DO   = do_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire
